// File: rtl/bus_device_responder.sv
// bus_device_responder: bus device that serves a local register file with wait states and a req/ack handshake
module bus_device_responder #(
  parameter int DEVICE_ID   = 1,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  device_en,
  input  logic [31:0] phys_addr,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;
  state_t state;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] a_addr, a_wdata, s_addr, s_wdata;
  logic [3:0]  a_be, s_be, cnt;
  logic        a_we, s_we, fail, accept, in_idle, go_resp, bad;
  logic [ADDR_WIDTH-1:0] idx;
  logic        unused_en;
  assign unused_en = ^device_en;
  assign in_idle = state == S_IDLE;
  assign accept  = in_idle && req && device_en[DEVICE_ID];
  // with no wait states the memory access happens on the acceptance edge, before the latches fill
  assign s_addr  = in_idle ? phys_addr : a_addr;
  assign s_wdata = in_idle ? wdata : a_wdata;
  assign s_be    = in_idle ? byte_en : a_be;
  assign s_we    = in_idle ? we : a_we;
  assign go_resp = in_idle ? accept && WAIT_STATES == 0
                           : state == S_WAIT && req && cnt == 4'(WAIT_STATES - 1);
  assign bad     = (|s_addr[1:0]) || (|s_addr[31:ADDR_WIDTH+2]);
  assign idx     = s_addr[ADDR_WIDTH+1:2];
  always_ff @(posedge clk) begin
    if (!rst && go_resp && !bad && s_we)
      for (int i = 0; i < 4; i++)
        if (s_be[i]) mem[idx][8*i +: 8] <= s_wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rdata <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      fail  <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (go_resp) begin
        fail <= bad;
        if (!bad && !s_we) rdata <= mem[idx];
      end
      case (state)
        S_IDLE: if (accept) begin
          a_addr  <= phys_addr;
          a_wdata <= wdata;
          a_be    <= byte_en;
          a_we    <= we;
          busy    <= 1'b1;
          cnt     <= '0;
          state   <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
        end
        S_WAIT: if (!req) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (go_resp) state <= S_RESP;
        else cnt <= cnt + 4'd1;
        S_RESP: begin
          ack   <= !fail;
          err   <= fail;
          state <= S_DONE;
        end
        S_DONE: if (!req) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_device_responder.sv
// tb_bus_device_responder: table-driven and scoreboarded checks of the bus device responder
module tb_bus_device_responder;
  localparam int WS = 2;
  logic clk = 0, rst, req, we, ack, err, busy;
  logic [7:0]  device_en;
  logic [31:0] phys_addr, wdata, rdata;
  logic [3:0]  byte_en;
  int tests = 0, fails = 0;
  typedef struct {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] b; logic e; logic [31:0] r;} vec_t;
  typedef struct {logic e; logic [31:0] r;} exp_t;
  exp_t q[$];
  vec_t tbl[14];
  always #5 clk = ~clk;
  bus_device_responder #(.DEVICE_ID(1), .ADDR_WIDTH(6), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .device_en(device_en), .phys_addr(phys_addr), .req(req), .we(we),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle_bus();
    req = 0; we = 0; device_en = 0; phys_addr = 0; wdata = 0; byte_en = 0;
  endtask
  task automatic xfer(input vec_t v);
    exp_t x;
    int cyc;
    q.push_back('{v.e, v.r});
    @(negedge clk);
    device_en = 8'h02; phys_addr = v.a; we = v.w; wdata = v.d; byte_en = v.b; req = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_on_accept", busy, 1);
        device_en = 8'h00; phys_addr = ~v.a; wdata = ~v.d; we = ~v.w; byte_en = ~v.b;
      end
    end while (!(ack || err) && cyc < 50);
    x = q.pop_front();
    check("latency", cyc, WS + 2);
    check("ack", ack, !x.e);
    check("err", err, x.e);
    check("rdata", rdata, x.r);
    @(negedge clk);
    check("pulse_len", {ack, err}, 0);
    check("busy_done", busy, 1);
    req = 0;
    @(negedge clk);
    check("busy_idle", busy, 0);
    idle_bus();
  endtask
  task automatic abort_after(input int k, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    device_en = 8'h02; phys_addr = a; we = 1; wdata = d; byte_en = 4'hF; req = 1;
    repeat (k) @(negedge clk);
    check("abort_busy", busy, 1);
    idle_bus();
    repeat (8) begin
      @(negedge clk);
      check("abort_quiet", {ack, err}, 0);
    end
    check("abort_idle", busy, 0);
  endtask
  task automatic foreign(input logic [7:0] en);
    @(negedge clk);
    device_en = en; phys_addr = 32'h20; we = 0; req = 1;
    repeat (20) begin
      @(negedge clk);
      check("foreign_quiet", {busy, ack, err}, 0);
    end
    idle_bus();
  endtask
  initial begin
    tbl[0]  = '{1'b1, 32'h000000A0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b0, 32'h000000A0, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h000000A0, 32'h0000AA00, 4'h2, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b0, 32'h000000A0, 32'h0,        4'h0, 1'b0, 32'hDEADAAEF};
    tbl[4]  = '{1'b0, 32'h00000009, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF};
    tbl[5]  = '{1'b1, 32'h00000000, 32'hCAFEF00D, 4'hF, 1'b0, 32'hDEADAAEF};
    tbl[6]  = '{1'b1, 32'h00000100, 32'h12345678, 4'hF, 1'b1, 32'hDEADAAEF};
    tbl[7]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};
    tbl[8]  = '{1'b1, 32'h000000FC, 32'h11223344, 4'hF, 1'b0, 32'hCAFEF00D};
    tbl[9]  = '{1'b1, 32'h000000FC, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hCAFEF00D};
    tbl[10] = '{1'b0, 32'h000000FC, 32'h0,        4'h0, 1'b0, 32'h11223344};
    tbl[11] = '{1'b0, 32'h000000A2, 32'h0,        4'h0, 1'b1, 32'h11223344};
    tbl[12] = '{1'b1, 32'h400000A0, 32'h00000000, 4'hF, 1'b1, 32'h11223344};
    tbl[13] = '{1'b0, 32'h000000A0, 32'h0,        4'h0, 1'b0, 32'hDEADAAEF};
    rst = 1;
    idle_bus();
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 0);
    check("reset_flags", {ack, err, busy}, 0);
    rst = 0;
    for (int i = 0; i < 14; i++) xfer(tbl[i]);
    foreign(8'h01);
    foreign(8'hFD);
    abort_after(1, 32'h0, 32'hBADBAD00);
    abort_after(2, 32'h0, 32'hBADBAD01);
    xfer('{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D});
    @(negedge clk);
    device_en = 8'h02; phys_addr = 32'h0; we = 1; wdata = 32'h55555555; byte_en = 4'hF; req = 1;
    @(negedge clk);
    check("rst_wait_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_flags", {ack, err}, 0);
    check("rst_rdata", rdata, 0);
    rst = 0;
    idle_bus();
    xfer('{1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D});
    xfer('{1'b1, 32'h04, 32'h01020304, 4'hF, 1'b0, 32'hCAFEF00D});
    xfer('{1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h01020304});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
